// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the PWM core and its step-detect helper.
package pwm_pkg;

    localparam int CNT_W_DFLT = 8;

    localparam logic [CNT_W_DFLT-1:0] PERIOD_RST = '1;
    localparam logic [CNT_W_DFLT-1:0] DUTY_RST   = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_if.sv
// Control/status bundle between a PWM consumer and pwm_core.
interface pwm_if #(
    parameter int CNT_W = 8
) ();

    logic             en;
    logic             tick_in;
    logic [CNT_W-1:0] duty_in;
    logic [CNT_W-1:0] period_in;
    logic             load;
    logic             load_ack;
    logic             pwm_out;
    logic             period_end;

    modport master (
        output en, tick_in, duty_in, period_in, load,
        input  load_ack, pwm_out, period_end
    );

    modport slave (
        input  en, tick_in, duty_in, period_in, load,
        output load_ack, pwm_out, period_end
    );

endinterface

// File: rtl/pwm_core_edge_rise.sv
// Rising-edge detector: turns a same-domain level (e.g. a divider output) into a one-cycle step.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= 1'b0;
        else        level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/pwm_core.sv
// PWM generator stepped by divider edges; period/duty are shadow-buffered and
// only take effect at RUN entry or at a period wrap.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
) (
    input logic  clk,
    input logic  rst_n,
    pwm_if.slave bus
);

    state_t           state_q, state_d;
    logic             step;
    logic             commit;
    logic             wrap;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] duty_act, period_act;
    logic [CNT_W-1:0] duty_pend, period_pend;
    logic             pend_valid;
    logic             pwm_q, period_end_q, load_ack_q;

    edge_rise u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.tick_in),
        .rise  (step)
    );

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        wrap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = RUN;
                    commit  = pend_valid;
                end
            end
            RUN: begin
                // Disable wins over a coincident wrap; pending stays for the next start.
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (step && (cnt_q == period_act)) begin
                    wrap   = 1'b1;
                    commit = pend_valid;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            period_end_q <= wrap;
            load_ack_q   <= commit;
            if (state_q == RUN && bus.en) begin
                // Compares the pre-update count, so pwm_out trails cnt by one clock.
                pwm_q <= (cnt_q < duty_act);
                if (wrap)      cnt_q <= '0;
                else if (step) cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
                pwm_q <= 1'b0;
            end
        end
    end

    // Commit reads the old pending pair; a same-cycle load refills pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act    <= CNT_W'(DUTY_RST);
            period_act  <= CNT_W'(PERIOD_RST);
            duty_pend   <= CNT_W'(DUTY_RST);
            period_pend <= CNT_W'(PERIOD_RST);
            pend_valid  <= 1'b0;
        end else begin
            if (commit) begin
                duty_act   <= duty_pend;
                period_act <= period_pend;
            end
            if (bus.load) begin
                duty_pend   <= bus.duty_in;
                period_pend <= bus.period_in;
                pend_valid  <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.period_end = period_end_q;
    assign bus.load_ack   = load_ack_q;

endmodule

// File: tb/tb_pwm_core.sv
// Scoreboard bench for pwm_core: a step/period model predicts {pwm_out, period_end, load_ack} per clock.
module tb_pwm_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pwm_if #(.CNT_W(8)) bus ();

    pwm_core #(.CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [2:0] exp_q[$];

    // Reference model: position within the period in steps, active and pending settings.
    bit m_run, m_tq, m_pv;
    int m_pos, m_duty, m_per, m_pduty, m_pper;

    // Tick generation
    bit rand_tick = 1'b0;
    int half      = 4;
    int tick_ctr  = 0;

    always @(posedge clk) begin : model
        logic [2:0] e;
        bit st;
        bit do_commit;
        cyc++;
        e = 3'b000;
        do_commit = 1'b0;
        if (!rst_n) begin
            m_run = 0; m_tq = 0; m_pos = 0; m_pv = 0;
            m_duty = 0; m_per = 255; m_pduty = 0; m_pper = 255;
        end else begin
            st   = bus.tick_in && !m_tq;
            m_tq = bus.tick_in;
            if (!m_run) begin
                m_pos = 0;
                if (bus.en) begin
                    m_run = 1;
                    do_commit = m_pv;
                end
            end else if (!bus.en) begin
                m_run = 0;
                m_pos = 0;
            end else begin
                e[2] = (m_pos < m_duty);
                if (st) begin
                    m_pos = (m_pos + 1) % (m_per + 1);
                    if (m_pos == 0) begin
                        e[1] = 1'b1;
                        do_commit = m_pv;
                    end
                end
            end
            if (do_commit) begin
                m_duty = m_pduty;
                m_per  = m_pper;
                m_pv   = 0;
                e[0]   = 1'b1;
            end
            if (bus.load) begin
                m_pduty = int'(bus.duty_in);
                m_pper  = int'(bus.period_in);
                m_pv    = 1;
            end
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        logic [2:0] e;
        logic [2:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {bus.pwm_out, bus.period_end, bus.load_ack};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d t=%0t pwm/pe/ack got %b required %b", cyc, $time, got, e);
            end
        end
    end

    task automatic drive_tick();
        if (rand_tick) begin
            bus.tick_in = 1'($urandom_range(0, 1));
        end else begin
            tick_ctr++;
            bus.tick_in = ((tick_ctr % (2 * half)) < half);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_tick();
            bus.load = 1'b0;
        end
    endtask

    task automatic load_vals(input int d, input int p);
        @(posedge clk);
        #1;
        drive_tick();
        bus.load      = 1'b1;
        bus.duty_in   = 8'(d);
        bus.period_in = 8'(p);
    endtask

    task automatic check_zero(input string name);
        logic [2:0] got;
        got = {bus.pwm_out, bus.period_end, bus.load_ack};
        n_cmp++;
        if (got !== 3'b000) begin
            n_bad++;
            $display("FAIL %s got %b required 000", name, got);
        end
    endtask

    initial begin
        bus.en        = 1'b0;
        bus.tick_in   = 1'b0;
        bus.load      = 1'b0;
        bus.duty_in   = '0;
        bus.period_in = '0;

        // Reset held with tick toggling
        rand_tick = 1'b1;
        cycles(10);
        check_zero("reset_hold");
        rst_n = 1'b1;
        rand_tick = 1'b0;
        half = 4;
        cycles(6);

        // Basic PWM 3/8
        load_vals(3, 7);
        cycles(2);
        bus.en = 1'b1;
        cycles(200);

        // Shadow update mid-period
        load_vals(6, 7);
        cycles(200);

        // Extremes
        load_vals(0, 7);
        cycles(150);
        load_vals(9, 7);
        cycles(150);
        load_vals(1, 0);
        cycles(100);

        // Double load before a boundary
        load_vals(3, 7);
        cycles(140);
        load_vals(2, 7);
        load_vals(5, 7);
        cycles(150);

        // Disable and re-enable
        cycles(37);
        bus.en = 1'b0;
        cycles(5);
        bus.en = 1'b1;
        cycles(100);

        // Asynchronous reset mid-period
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        cycles(3);
        rst_n = 1'b1;
        cycles(120);

        // Randomized phase
        rand_tick = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                load_vals(int'($urandom_range(0, 12)), int'($urandom_range(0, 10)));
            end else begin
                cycles(1);
            end
            if ($urandom_range(0, 99) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                check_zero("rand_reset");
                cycles(2);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
